// File: rtl/unique_sel_arbiter_pkg.sv
// Shared types and helpers for the unique/priority selection arbiter.
// Holds the resolution-mode enum, the index-width helper and the saturating increment.
package sel_pkg;

    typedef enum logic [1:0] {
        SEL_PRIORITY,
        SEL_UNIQUE,
        SEL_UNIQUE0
    } sel_mode_e;

    // Width of an index into n lines; never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // v + 1, but held at 2^w-1 once that ceiling is reached.
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input int w);
        logic [63:0] ceil_v;
        ceil_v = (64'd1 << w) - 64'd1;
        if ({32'd0, v} >= ceil_v) begin
            return v;
        end
        return v + 32'd1;
    endfunction

endpackage

// File: rtl/unique_sel_arbiter_if.sv
// Request/grant bus of the selection arbiter.
// Handshake: a transfer happens on a rising edge where valid && ready; the producer holds its fields while valid && !ready.
interface unique_sel_arbiter_if
    import sel_pkg::*;
#(
    parameter int N = 4
);
    logic                  req_valid;
    logic [N-1:0]          req;
    logic                  req_ready;
    logic                  gnt_valid;
    logic                  gnt_ready;
    logic [N-1:0]          gnt;
    logic [idx_w(N)-1:0]   gnt_idx;
    logic                  gnt_none;
    logic                  err_multi;
    logic                  err_none;

    modport master (
        output req_valid, req, gnt_ready,
        input  req_ready, gnt_valid, gnt, gnt_idx, gnt_none, err_multi, err_none
    );

    modport slave (
        input  req_valid, req, gnt_ready,
        output req_ready, gnt_valid, gnt, gnt_idx, gnt_none, err_multi, err_none
    );
endinterface

// File: rtl/unique_sel_arbiter_resolve.sv
// Combinational resolver: lowest set request line wins, plus overlap and no-match detection.
module sel_resolve
    import sel_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]        req,
    output logic [N-1:0]        gnt,
    output logic [idx_w(N)-1:0] idx,
    output logic                multi,
    output logic                none
);
    localparam int IW = idx_w(N);

    // Two's-complement trick isolates the lowest set bit; clearing it exposes any overlap.
    assign gnt   = req & (~req + N'(1));
    assign multi = (req & (req - N'(1))) != '0;
    assign none  = (req == '0);

    always_comb begin
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = IW'(i);
            end
        end
    end
endmodule

// File: rtl/unique_sel_arbiter.sv
// Registered, handshaked N-way selector with priority/unique/unique0 semantics.
// Violations are flagged per result, counted in saturating counters and latched sticky.
module unique_sel_arbiter
    import sel_pkg::*;
#(
    parameter int        N     = 4,
    parameter sel_mode_e MODE  = SEL_UNIQUE,
    parameter int        CNT_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    unique_sel_arbiter_if.slave bus,
    input  logic               clr_err,
    output logic [CNT_W-1:0]   multi_cnt,
    output logic [CNT_W-1:0]   none_cnt,
    output logic               sticky_err
);
    localparam int IW = idx_w(N);

    logic [N-1:0]  res_gnt;
    logic [IW-1:0] res_idx;
    logic          res_multi;
    logic          res_none;

    sel_resolve #(.N(N)) u_resolve (
        .req   (bus.req),
        .gnt   (res_gnt),
        .idx   (res_idx),
        .multi (res_multi),
        .none  (res_none)
    );

    logic          gnt_valid_q;
    logic [N-1:0]  gnt_q;
    logic [IW-1:0] gnt_idx_q;
    logic          gnt_none_q;
    logic          err_multi_q;
    logic          err_none_q;

    logic accept;
    logic em_next;
    logic en_next;

    assign bus.req_ready = !gnt_valid_q || bus.gnt_ready;
    assign accept        = bus.req_valid && bus.req_ready;

    // Priority mode never flags; unique0 tolerates an empty request vector.
    assign em_next = (MODE != SEL_PRIORITY) && res_multi;
    assign en_next = (MODE == SEL_UNIQUE) && res_none;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt_valid_q <= 1'b0;
            gnt_q       <= '0;
            gnt_idx_q   <= '0;
            gnt_none_q  <= 1'b0;
            err_multi_q <= 1'b0;
            err_none_q  <= 1'b0;
        end else if (accept) begin
            gnt_valid_q <= 1'b1;
            gnt_q       <= res_gnt;
            gnt_idx_q   <= res_idx;
            gnt_none_q  <= res_none;
            err_multi_q <= em_next;
            err_none_q  <= en_next;
        end else if (bus.gnt_ready) begin
            gnt_valid_q <= 1'b0;
        end
    end

    assign bus.gnt_valid = gnt_valid_q;
    assign bus.gnt       = gnt_q;
    assign bus.gnt_idx   = gnt_idx_q;
    assign bus.gnt_none  = gnt_none_q;
    assign bus.err_multi = err_multi_q;
    assign bus.err_none  = err_none_q;

    logic [CNT_W-1:0] mc_base, nc_base, mc_next, nc_next;
    logic             sticky_next;

    // A clear in the same cycle as a violation is applied first, so the event still counts.
    always_comb begin
        mc_base = clr_err ? '0 : multi_cnt;
        nc_base = clr_err ? '0 : none_cnt;
        mc_next = mc_base;
        nc_next = nc_base;
        if (accept && em_next) begin
            mc_next = CNT_W'(sat_inc(32'(mc_base), CNT_W));
        end
        if (accept && en_next) begin
            nc_next = CNT_W'(sat_inc(32'(nc_base), CNT_W));
        end
        sticky_next = (clr_err ? 1'b0 : sticky_err) | (accept && (em_next || en_next));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            multi_cnt  <= '0;
            none_cnt   <= '0;
            sticky_err <= 1'b0;
        end else begin
            multi_cnt  <= mc_next;
            none_cnt   <= nc_next;
            sticky_err <= sticky_next;
        end
    end
endmodule
